// File: rtl/wb_write_arbiter.sv
// wb_write_arbiter
//   Single write-port master for the 32 x XLEN integer register file.
//   Merges the in-order pipeline writeback (priority) with a long-latency
//   result stream buffered in a DEPTH-entry FIFO. It also reports per-source
//   "pending write" flags that the hazard unit uses to stall dependent reads.
//   Writes to x0 from either source are dropped. A pipeline write to x0 is
//   treated as an idle cycle, so the FIFO can drain during it.
//
//   Optional feature macro: WB_ARB_STARVE_CNT_EN
//     Adds output starve_cnt, a saturating count of the cycles in which queued
//     long-latency results were held back by a valid pipeline write.
module wb_write_arbiter #(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            reset,
    // pipeline writeback, always accepted
    input  logic            pipe_we,
    input  logic [4:0]      pipe_rd,
    input  logic [XLEN-1:0] pipe_data,
    // long-latency result stream
    input  logic            ll_valid,
    output logic            ll_ready,
    input  logic [4:0]      ll_rd,
    input  logic [XLEN-1:0] ll_data,
    // register file write port
    output logic            rf_we,
    output logic [4:0]      rf_rd,
    output logic [XLEN-1:0] rf_wdata,
    // hazard queries
    input  logic [4:0]      rs1,
    input  logic [4:0]      rs2,
    output logic            rs1_pending,
    output logic            rs2_pending,
    output logic [CW-1:0]   fifo_count
`ifdef WB_ARB_STARVE_CNT_EN
    ,
    output logic [31:0]     starve_cnt
`endif
);

    localparam int unsigned PW = $clog2(DEPTH);

    // FIFO storage. Only the valid bits need a reset. The payload is
    // qualified by those bits everywhere it is used.
    logic [4:0]      ent_rd   [DEPTH];
    logic [XLEN-1:0] ent_data [DEPTH];
    logic [DEPTH-1:0] ent_valid;
    logic [PW-1:0]   head;
    logic [PW-1:0]   tail;
    logic [CW-1:0]   count;

    logic pipe_sel;
    logic do_pop;
    logic do_push;
    logic rs1_hit;
    logic rs2_hit;

    // Acceptance depends only on the registered count. A pop in the same
    // cycle does not free a slot until the next cycle.
    assign ll_ready   = (count < CW'(DEPTH));
    assign fifo_count = count;

    // Issue and handshake decisions for this cycle.
    always_comb begin
        pipe_sel = pipe_we && (pipe_rd != 5'd0);
        do_pop   = !pipe_sel && (count != '0);
        do_push  = ll_valid && ll_ready && (ll_rd != 5'd0);
    end

    // FIFO payload write at the tail. The payload is not reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            ent_rd[tail]   <= ll_rd;
            ent_data[tail] <= ll_data;
        end
    end

    // FIFO control: valid bits, pointers and occupancy.
    always_ff @(posedge clk) begin
        if (reset) begin
            ent_valid <= '0;
            head      <= '0;
            tail      <= '0;
            count     <= '0;
        end else begin
            // push requires count < DEPTH and pop requires count > 0, so
            // head and tail never name the same slot when both fire
            if (do_push) begin
                ent_valid[tail] <= 1'b1;
                tail            <= tail + PW'(1);
            end
            if (do_pop) begin
                ent_valid[head] <= 1'b0;
                head            <= head + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Registered write port. The pipeline has priority, then the FIFO head.
    always_ff @(posedge clk) begin
        if (reset) begin
            rf_we    <= 1'b0;
            rf_rd    <= '0;
            rf_wdata <= '0;
        end else if (pipe_sel) begin
            rf_we    <= 1'b1;
            rf_rd    <= pipe_rd;
            rf_wdata <= pipe_data;
        end else if (do_pop) begin
            rf_we    <= 1'b1;
            rf_rd    <= ent_rd[head];
            rf_wdata <= ent_data[head];
        end else begin
            rf_we    <= 1'b0;
        end
    end

    // Match both source queries against every queued destination.
    always_comb begin
        rs1_hit = 1'b0;
        rs2_hit = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (ent_valid[i] && (ent_rd[i] == rs1)) rs1_hit = 1'b1;
            if (ent_valid[i] && (ent_rd[i] == rs2)) rs2_hit = 1'b1;
        end
    end

    // Pending = queued in FIFO or landing at the coming edge; x0 never pends.
    always_comb begin
        rs1_pending = (rs1 != 5'd0) && (rs1_hit || (rf_we && (rf_rd == rs1)));
        rs2_pending = (rs2 != 5'd0) && (rs2_hit || (rf_we && (rf_rd == rs2)));
    end

`ifdef WB_ARB_STARVE_CNT_EN
    // Count cycles where queued results lose arbitration. The count saturates.
    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (pipe_sel && (count != '0) && (starve_cnt != '1)) begin
            starve_cnt <= starve_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_wb_write_arbiter.sv
// tb_wb_write_arbiter
//   Directed test-plan sequences followed by randomized traffic. The DUT is
//   compared every cycle against a queue-based behavioural model.
module tb_wb_write_arbiter;

    localparam int unsigned XLEN  = 64;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = $clog2(DEPTH + 1);

    logic            clk = 1'b0;
    logic            reset;
    logic            pipe_we;
    logic [4:0]      pipe_rd;
    logic [XLEN-1:0] pipe_data;
    logic            ll_valid;
    logic            ll_ready;
    logic [4:0]      ll_rd;
    logic [XLEN-1:0] ll_data;
    logic            rf_we;
    logic [4:0]      rf_rd;
    logic [XLEN-1:0] rf_wdata;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic            rs1_pending;
    logic            rs2_pending;
    logic [CW-1:0]   fifo_count;
`ifdef WB_ARB_STARVE_CNT_EN
    logic [31:0]     starve_cnt;
`endif

    int unsigned vec  = 0;
    int unsigned errs = 0;

    wb_write_arbiter #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .pipe_we(pipe_we), .pipe_rd(pipe_rd), .pipe_data(pipe_data),
        .ll_valid(ll_valid), .ll_ready(ll_ready), .ll_rd(ll_rd), .ll_data(ll_data),
        .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata),
        .rs1(rs1), .rs2(rs2), .rs1_pending(rs1_pending), .rs2_pending(rs2_pending),
        .fifo_count(fifo_count)
`ifdef WB_ARB_STARVE_CNT_EN
        , .starve_cnt(starve_cnt)
`endif
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } ent_t;

    ent_t            mq[$];
    bit              m_started = 0;
    bit              m_we;
    logic [4:0]      m_rd;
    logic [XLEN-1:0] m_data;
    longint unsigned m_starve;

    function automatic bit m_pend(logic [4:0] rs);
        if (rs == 5'd0) return 1'b0;
        if (m_we && m_rd == rs) return 1'b1;
        foreach (mq[i]) if (mq[i].rd == rs) return 1'b1;
        return 1'b0;
    endfunction

    always @(posedge clk) begin : model
        bit   psel;
        bit   rdy;
        ent_t e;
        if (reset) begin
            mq.delete();
            m_we      = 1'b0;
            m_rd      = '0;
            m_data    = '0;
            m_starve  = 0;
            m_started = 1'b1;
        end else if (m_started) begin
            psel = pipe_we && (pipe_rd != 0);
            rdy  = (mq.size() < DEPTH);
            if (psel && mq.size() > 0 && m_starve < 64'hFFFF_FFFF) m_starve++;
            if (psel) begin
                m_we = 1'b1; m_rd = pipe_rd; m_data = pipe_data;
            end else if (mq.size() > 0) begin
                e = mq.pop_front();
                m_we = 1'b1; m_rd = e.rd; m_data = e.data;
            end else begin
                m_we = 1'b0;
            end
            if (ll_valid && rdy && ll_rd != 0) begin
                e.rd = ll_rd; e.data = ll_data;
                mq.push_back(e);
            end
        end
    end

    task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        vec++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare the DUT against the model every cycle, away from the clock edge.
    always @(negedge clk) begin
        if (m_started) begin
            chk("rf_we",       rf_we,       m_we);
            chk("rf_rd",       rf_rd,       m_rd);
            chk("rf_wdata",    rf_wdata,    m_data);
            chk("fifo_count",  fifo_count,  mq.size());
            chk("ll_ready",    ll_ready,    mq.size() < DEPTH);
            chk("rs1_pending", rs1_pending, m_pend(rs1));
            chk("rs2_pending", rs2_pending, m_pend(rs2));
`ifdef WB_ARB_STARVE_CNT_EN
            chk("starve_cnt",  starve_cnt,  m_starve);
`endif
        end
    end

    // Advance one clock. Directed checks and new inputs follow at posedge+2.
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    initial begin
        int unsigned pipe_pct;
        reset = 1'b1; pipe_we = 0; pipe_rd = 0; pipe_data = 0;
        ll_valid = 0; ll_rd = 0; ll_data = 0; rs1 = 0; rs2 = 0;

        // reset then idle
        cyc(); cyc();
        reset = 1'b0; rs1 = 5; rs2 = 7;
        #1;
        chk("rst_rf_we", rf_we, 0);
        chk("rst_rf_rd", rf_rd, 0);
        chk("rst_rf_wdata", rf_wdata, 0);
        chk("rst_count", fifo_count, 0);
        chk("rst_ll_ready", ll_ready, 1);
        chk("rst_rs1_pend", rs1_pending, 0);
        chk("rst_rs2_pend", rs2_pending, 0);

        // pipe only
        pipe_we = 1; pipe_rd = 5; pipe_data = 64'h1234;
        cyc();
        pipe_we = 0;
        chk("pipe_we", rf_we, 1);
        chk("pipe_rd", rf_rd, 5);
        chk("pipe_wdata", rf_wdata, 64'h1234);
        cyc();
        chk("pipe_we_off", rf_we, 0);

        // priority / starvation
        rs1 = 7; rs2 = 0;
        ll_valid = 1; ll_rd = 7; ll_data = 64'hAA;
        pipe_we = 1; pipe_rd = 3; pipe_data = 64'h33;
        for (int i = 0; i < 3; i++) begin
            cyc();
            ll_valid = 0;
            chk("prio_rd3", rf_rd, 3);
            chk("prio_rs1_pend", rs1_pending, 1);
        end
        pipe_we = 0;
        cyc();
        chk("prio_ll_we", rf_we, 1);
        chk("prio_ll_rd", rf_rd, 7);
        chk("prio_ll_data", rf_wdata, 64'hAA);
        cyc();
        chk("prio_rs1_clear", rs1_pending, 0);

        // full FIFO
        pipe_we = 1; pipe_rd = 3;
        for (int r = 1; r <= 4; r++) begin
            ll_valid = 1; ll_rd = 5'(r); ll_data = 64'(r * 16);
            cyc();
        end
        ll_rd = 9; ll_data = 64'h99;
        #1;
        chk("full_count", fifo_count, 4);
        chk("full_ready", ll_ready, 0);
        cyc();
        chk("full_reject", fifo_count, 4);
        ll_valid = 0; pipe_we = 0;
        for (int r = 1; r <= 4; r++) begin
            cyc();
            chk("drain_we", rf_we, 1);
            chk("drain_rd", rf_rd, 5'(r));
            chk("drain_data", rf_wdata, 64'(r * 16));
            if (r == 1) chk("drain_ready", ll_ready, 1);
        end
        cyc();
        chk("drain_idle", rf_we, 0);

        // x0 handling
        ll_valid = 1; ll_rd = 0; ll_data = 64'hDEAD;
        cyc();
        ll_valid = 0;
        chk("x0_push_count", fifo_count, 0);
        pipe_we = 1; pipe_rd = 3; ll_valid = 1; ll_rd = 6; ll_data = 64'h66;
        cyc();
        ll_valid = 0; pipe_rd = 0;
        cyc();
        pipe_we = 0;
        chk("x0_pipe_we", rf_we, 1);
        chk("x0_pipe_rd", rf_rd, 6);
        rs1 = 0;
        #1;
        chk("x0_rs1_pend", rs1_pending, 0);
        cyc();

        // reset mid-operation
        pipe_we = 1; pipe_rd = 3;
        for (int r = 10; r <= 12; r++) begin
            ll_valid = 1; ll_rd = 5'(r); ll_data = 64'(r);
            cyc();
        end
        ll_valid = 0;
        chk("mid_count", fifo_count, 3);
        reset = 1; pipe_we = 0;
        cyc();
        reset = 0; rs1 = 10; rs2 = 11;
        #1;
        chk("mid_rst_count", fifo_count, 0);
        chk("mid_rst_we", rf_we, 0);
        chk("mid_rst_rs1", rs1_pending, 0);
        chk("mid_rst_rs2", rs2_pending, 0);
        cyc();
        chk("mid_rst_no_issue", rf_we, 0);

        // randomized traffic in phases of varying pipeline load
        pipe_pct = 50;
        for (int n = 0; n < 3000; n++) begin
            if (n % 100 == 0) pipe_pct = $urandom_range(0, 2) * 40 + 10;
            reset     = ($urandom_range(0, 249) == 0);
            pipe_we   = ($urandom_range(0, 99) < pipe_pct);
            pipe_rd   = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 7));
            pipe_data = {$urandom, $urandom};
            ll_valid  = $urandom_range(0, 1);
            ll_rd     = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 7));
            ll_data   = {$urandom, $urandom};
            rs1       = 5'($urandom_range(0, 8));
            rs2       = 5'($urandom_range(0, 8));
            cyc();
        end
        reset = 0; pipe_we = 0; ll_valid = 0;
        cyc(); cyc();

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
